// File: rtl/pipelined_hazard_scoreboard.sv
// Register hazard scoreboard: tracks destinations of issued-but-not-written-back
// instructions and stalls decode on RAW, WAW or a full in-flight window.
module pipelined_hazard_scoreboard #(
    parameter int MAX_INFLIGHT = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  dec_valid,
    input  logic [4:0]                            dec_instruction_type,
    input  logic [4:0]                            dec_reg_0,
    input  logic [4:0]                            dec_reg_1,
    input  logic [4:0]                            dec_reg_res,
    input  logic                                  wb_valid,
    input  logic [4:0]                            wb_reg,
    input  logic                                  flush,
    output logic                                  stall,
    output logic                                  issue,
    output logic [31:0]                           pending_mask,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]     inflight_count,
    output logic [15:0]                           stall_cycles,
    output logic                                  wb_error
);
    localparam int CW = $clog2(MAX_INFLIGHT + 1);

    // Instruction codes shared with the architecture definitions
    localparam logic [4:0] INSTR_ALU_OP         = 5'd1;
    localparam logic [4:0] INSTR_LOAD           = 5'd2;
    localparam logic [4:0] INSTR_STORE          = 5'd3;
    localparam logic [4:0] INSTR_JUMP           = 5'd4;
    localparam logic [4:0] INSTR_LOAD_IMMEDIATE = 5'd5;

    logic [31:0]   pending_q, pending_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   stall_cycles_q, stall_cycles_d;
    logic          wb_error_q, wb_error_d;

    logic src0_used, src1_used, dst_used;
    logic raw, waw, full;
    logic wb_hit, do_set;

    always_comb begin
        src0_used = 1'b0;
        src1_used = 1'b0;
        dst_used  = 1'b0;
        case (dec_instruction_type)
            INSTR_ALU_OP: begin
                src0_used = 1'b1;
                src1_used = 1'b1;
                dst_used  = 1'b1;
            end
            INSTR_STORE, INSTR_JUMP: begin
                src0_used = 1'b1;
                src1_used = 1'b1;
            end
            INSTR_LOAD: begin
                src0_used = 1'b1;
                dst_used  = 1'b1;
            end
            INSTR_LOAD_IMMEDIATE: dst_used = 1'b1;
            default: ;
        endcase
    end

    // Hazards look only at registered state, so a same-cycle write-back
    // releases a stall one cycle later.
    always_comb begin
        raw   = (src0_used && pending_q[dec_reg_0]) || (src1_used && pending_q[dec_reg_1]);
        waw   = dst_used && pending_q[dec_reg_res];
        full  = dst_used && (count_q == CW'(MAX_INFLIGHT));
        stall = dec_valid && !flush && (raw || waw || full);
        issue = dec_valid && !stall && !flush;
    end

    always_comb begin
        pending_d      = pending_q;
        count_d        = count_q;
        wb_error_d     = wb_error_q;
        stall_cycles_d = stall_cycles_q;
        wb_hit         = wb_valid && pending_q[wb_reg];
        do_set         = issue && dst_used;

        if (stall && (stall_cycles_q != 16'hFFFF))
            stall_cycles_d = stall_cycles_q + 16'd1;

        if (flush) begin
            pending_d = '0;
            count_d   = '0;
        end else begin
            if (wb_valid && !wb_hit)
                wb_error_d = 1'b1;
            // Clear before set so an issue to the retiring register keeps the bit
            if (wb_hit)
                pending_d[wb_reg] = 1'b0;
            if (do_set)
                pending_d[dec_reg_res] = 1'b1;
            if (do_set && !wb_hit && (count_q != CW'(MAX_INFLIGHT)))
                count_d = count_q + CW'(1);
            else if (wb_hit && !do_set && (count_q != '0))
                count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q      <= '0;
            count_q        <= '0;
            stall_cycles_q <= '0;
            wb_error_q     <= 1'b0;
        end else begin
            pending_q      <= pending_d;
            count_q        <= count_d;
            stall_cycles_q <= stall_cycles_d;
            wb_error_q     <= wb_error_d;
        end
    end

    assign pending_mask   = pending_q;
    assign inflight_count = count_q;
    assign stall_cycles   = stall_cycles_q;
    assign wb_error       = wb_error_q;
endmodule

// File: tb/tb_pipelined_hazard_scoreboard.sv
// Bench for pipelined_hazard_scoreboard: directed vector table, random traffic
// against a queue-based reference model, and saturation/reset corner cases.
module tb_pipelined_hazard_scoreboard;
    localparam logic [4:0] ALU = 5'd1, LD = 5'd2, ST = 5'd3, JMP = 5'd4, LI = 5'd5;

    logic        clk = 0, rst = 1;
    logic        dec_valid = 0, wb_valid = 0, flush = 0;
    logic [4:0]  dec_instruction_type = 0, dec_reg_0 = 0, dec_reg_1 = 0, dec_reg_res = 0, wb_reg = 0;
    logic        stall, issue, wb_error;
    logic [31:0] pending_mask;
    logic [1:0]  inflight_count;
    logic [15:0] stall_cycles;

    int total = 0, bad = 0;

    pipelined_hazard_scoreboard #(.MAX_INFLIGHT(3)) dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid),
        .dec_instruction_type(dec_instruction_type), .dec_reg_0(dec_reg_0),
        .dec_reg_1(dec_reg_1), .dec_reg_res(dec_reg_res), .wb_valid(wb_valid),
        .wb_reg(wb_reg), .flush(flush), .stall(stall), .issue(issue),
        .pending_mask(pending_mask), .inflight_count(inflight_count),
        .stall_cycles(stall_cycles), .wb_error(wb_error)
    );

    always #5 clk = ~clk;

    // Reference model: list of registers awaiting write-back.
    int m_q[$];
    bit m_werr = 0;
    int m_scyc = 0;
    bit m_stall, m_issue;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_pend(input int r);
        foreach (m_q[i]) if (m_q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_mask();
        logic [31:0] m = '0;
        foreach (m_q[i]) m[m_q[i]] = 1'b1;
        return m;
    endfunction

    function automatic bit reads0(input logic [4:0] t);
        return (t == ALU) || (t == ST) || (t == JMP) || (t == LD);
    endfunction
    function automatic bit reads1(input logic [4:0] t);
        return (t == ALU) || (t == ST) || (t == JMP);
    endfunction
    function automatic bit writes(input logic [4:0] t);
        return (t == ALU) || (t == LD) || (t == LI);
    endfunction

    // Apply one cycle of inputs, check every output against the model, advance the model.
    task automatic cycle(input bit dv, input logic [4:0] t, r0, r1, rd,
                         input bit wv, input logic [4:0] wr, input bit fl);
        bit hazard;
        int idx;
        @(negedge clk);
        dec_valid = dv; dec_instruction_type = t; dec_reg_0 = r0; dec_reg_1 = r1;
        dec_reg_res = rd; wb_valid = wv; wb_reg = wr; flush = fl;
        #1;
        hazard = (reads0(t) && is_pend(r0)) || (reads1(t) && is_pend(r1)) ||
                 (writes(t) && (is_pend(rd) || m_q.size() == 3));
        m_stall = dv && !fl && hazard;
        m_issue = dv && !fl && !hazard;
        chk("stall", {31'b0, stall}, {31'b0, m_stall});
        chk("issue", {31'b0, issue}, {31'b0, m_issue});
        chk("pending_mask", pending_mask, m_mask());
        chk("inflight_count", {30'b0, inflight_count}, 32'(m_q.size()));
        chk("stall_cycles", {16'b0, stall_cycles}, 32'(m_scyc));
        chk("wb_error", {31'b0, wb_error}, {31'b0, m_werr});
        if (m_stall && m_scyc < 65535) m_scyc++;
        if (fl) m_q.delete();
        else begin
            if (wv) begin
                idx = -1;
                foreach (m_q[i]) if (m_q[i] == wr) idx = i;
                if (idx >= 0) m_q.delete(idx);
                else m_werr = 1;
            end
            if (m_issue && writes(t)) m_q.push_back(int'(rd));
        end
    endtask

    typedef struct {
        bit dv; logic [4:0] t, r0, r1, rd; bit wv; logic [4:0] wr; bit fl;
        bit e_stall, e_issue; logic [31:0] e_mask; int e_cnt; bit e_werr; int e_scyc;
    } vec_t;
    vec_t vt[26];

    function automatic vec_t mk(bit dv, logic [4:0] t, r0, r1, rd, bit wv, logic [4:0] wr, bit fl,
                                bit es, ei, logic [31:0] em, int ec, bit ew, int esc);
        vec_t v;
        v.dv = dv; v.t = t; v.r0 = r0; v.r1 = r1; v.rd = rd; v.wv = wv; v.wr = wr; v.fl = fl;
        v.e_stall = es; v.e_issue = ei; v.e_mask = em; v.e_cnt = ec; v.e_werr = ew; v.e_scyc = esc;
        return v;
    endfunction

    initial begin
        // dv type r0 r1 rd wv wr fl | stall issue mask cnt werr scyc
        vt[0]  = mk(1, LI,  0, 0, 5, 0, 0, 0, 0, 1, 32'h00, 0, 0, 0);
        vt[1]  = mk(1, ALU, 5, 6, 7, 0, 0, 0, 1, 0, 32'h20, 1, 0, 0);
        vt[2]  = mk(1, ALU, 5, 6, 7, 1, 5, 0, 1, 0, 32'h20, 1, 0, 1);
        vt[3]  = mk(1, ALU, 5, 6, 7, 0, 0, 0, 0, 1, 32'h00, 0, 0, 2);
        vt[4]  = mk(0, 0,   0, 0, 0, 0, 0, 1, 0, 0, 32'h80, 1, 0, 2);
        vt[5]  = mk(1, LI,  0, 0, 1, 0, 0, 0, 0, 1, 32'h00, 0, 0, 2);
        vt[6]  = mk(1, LI,  0, 0, 2, 0, 0, 0, 0, 1, 32'h02, 1, 0, 2);
        vt[7]  = mk(1, LI,  0, 0, 3, 0, 0, 0, 0, 1, 32'h06, 2, 0, 2);
        vt[8]  = mk(1, LI,  0, 0, 4, 0, 0, 0, 1, 0, 32'h0E, 3, 0, 2);
        vt[9]  = mk(1, ST,  7, 8, 4, 0, 0, 0, 0, 1, 32'h0E, 3, 0, 3);
        vt[10] = mk(1, LI,  0, 0, 9, 0, 0, 1, 0, 0, 32'h0E, 3, 0, 3);
        vt[11] = mk(0, 0,   0, 0, 0, 1, 2, 0, 0, 0, 32'h00, 0, 0, 3);
        vt[12] = mk(0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 32'h00, 0, 1, 3);
        vt[13] = mk(0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 32'h00, 0, 1, 3);
        vt[14] = mk(1, LI,  0, 0, 1, 0, 0, 0, 0, 1, 32'h00, 0, 1, 3);
        vt[15] = mk(1, LI,  0, 0, 1, 1, 1, 0, 1, 0, 32'h02, 1, 1, 3);
        vt[16] = mk(1, LI,  0, 0, 1, 0, 0, 0, 0, 1, 32'h00, 0, 1, 4);
        vt[17] = mk(0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 32'h02, 1, 1, 4);
        vt[18] = mk(1, LI,  0, 0, 3, 1, 1, 0, 0, 1, 32'h02, 1, 1, 4);
        vt[19] = mk(0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 32'h08, 1, 1, 4);
        vt[20] = mk(1, LI,  0, 0, 0, 0, 0, 0, 0, 1, 32'h08, 1, 1, 4);
        vt[21] = mk(1, LD,  0, 9, 10,0, 0, 0, 1, 0, 32'h09, 2, 1, 4);
        vt[22] = mk(1, JMP, 31,0, 0, 0, 0, 0, 1, 0, 32'h09, 2, 1, 5);
        vt[23] = mk(0, 0,   0, 0, 0, 1, 0, 0, 0, 0, 32'h09, 2, 1, 6);
        vt[24] = mk(1, JMP, 31,0, 0, 0, 0, 0, 0, 1, 32'h08, 1, 1, 6);
        vt[25] = mk(1, 5'd31,3, 3, 3, 0, 0, 0, 0, 1, 32'h08, 1, 1, 6);

        // Reset state while rst is held
        dec_valid = 1;
        #12;
        chk("rst_mask", pending_mask, 32'h0);
        chk("rst_cnt", {30'b0, inflight_count}, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_issue", {31'b0, issue}, 32'h1);
        chk("rst_werr", {31'b0, wb_error}, 32'h0);
        @(negedge clk);
        dec_valid = 0;
        rst = 0;

        foreach (vt[i]) begin
            cycle(vt[i].dv, vt[i].t, vt[i].r0, vt[i].r1, vt[i].rd, vt[i].wv, vt[i].wr, vt[i].fl);
            chk($sformatf("vec%0d_stall", i), {31'b0, stall}, {31'b0, vt[i].e_stall});
            chk($sformatf("vec%0d_issue", i), {31'b0, issue}, {31'b0, vt[i].e_issue});
            chk($sformatf("vec%0d_mask", i), pending_mask, vt[i].e_mask);
            chk($sformatf("vec%0d_cnt", i), {30'b0, inflight_count}, 32'(vt[i].e_cnt));
            chk($sformatf("vec%0d_werr", i), {31'b0, wb_error}, {31'b0, vt[i].e_werr});
            chk($sformatf("vec%0d_scyc", i), {16'b0, stall_cycles}, 32'(vt[i].e_scyc));
        end

        // Random traffic on a small register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] t, r0, r1, rd, wr;
            bit dv, wv, fl;
            t  = 5'($urandom_range(0, 7));
            r0 = 5'($urandom_range(0, 7));
            r1 = 5'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 7));
            dv = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 49) == 0);
            wv = !fl && ($urandom_range(0, 2) == 0);
            if (m_q.size() > 0 && $urandom_range(0, 9) != 0)
                wr = 5'(m_q[$urandom_range(0, m_q.size() - 1)]);
            else
                wr = 5'($urandom_range(0, 31));
            cycle(dv, t, r0, r1, rd, wv, wr, fl);
        end

        // Long RAW stall saturates the stall counter
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        cycle(1, LI, 0, 0, 5, 0, 0, 0);
        cycle(1, ALU, 5, 6, 7, 0, 0, 0);
        for (int n = 0; n < 70000; n++) @(posedge clk);
        @(negedge clk);
        #1;
        chk("sat_stall", {31'b0, stall}, 32'h1);
        chk("sat_scyc", {16'b0, stall_cycles}, 32'h0000FFFF);
        chk("sat_mask", pending_mask, 32'h20);

        // Asynchronous reset mid-cycle clears everything at once
        #2 rst = 1;
        #1;
        chk("arst_mask", pending_mask, 32'h0);
        chk("arst_cnt", {30'b0, inflight_count}, 32'h0);
        chk("arst_scyc", {16'b0, stall_cycles}, 32'h0);
        chk("arst_werr", {31'b0, wb_error}, 32'h0);
        chk("arst_stall", {31'b0, stall}, 32'h0);
        chk("arst_issue", {31'b0, issue}, 32'h1);
        @(negedge clk);
        dec_valid = 0;
        rst = 0;
        m_q.delete();
        m_werr = 0;
        m_scyc = 0;

        // Write-back of a register discarded by reset is an error
        cycle(0, 0, 0, 0, 0, 1, 5, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_werr", {31'b0, wb_error}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
